// File: rtl/prim_fifo_wr_arb_pkg.sv
// Package for prim_fifo_wr_arb.
// Purpose : shared types and helpers for the FIFO write-port arbiter.
// Contents: arb_state_e  - arbiter lock state (idle / packet locked)
//           rr_next()    - round-robin pointer successor with wrap at n
package prim_fifo_wr_arb_pkg;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  // Successor of idx in a ring of n slots (n-1 wraps to 0).
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/prim_rr_pick.sv
// prim_rr_pick: combinational round-robin picker.
// Purpose : find the first asserted request scanning start_i, start_i+1, ...
//           modulo N.
// Ports   : req_i   [N-1:0]    request vector
//           start_i [IdxW-1:0] highest-priority index this cycle
//           valid_o            at least one request asserted
//           idx_o   [IdxW-1:0] winning index (0 when valid_o is low)
module prim_rr_pick #(
  parameter int N    = 4,
  parameter int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  int j;

  // Scan from the farthest offset down to offset 0 so that the nearest
  // request to start_i overwrites any farther one.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j[IdxW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = j[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/prim_fifo_wr_arb.sv
// prim_fifo_wr_arb: round-robin arbiter sharing one FIFO write port.
// Purpose : N requesters compete for the write port of a prim_fifo_sync.
//           A multi-beat packet keeps the grant until its last beat (or
//           until MaxBurst beats, when the lock is forcibly released), so
//           packets never interleave. Every beat is tagged with its source.
// Ports   : clk_i, rst_ni (async, active low), clr_i (sync clear)
//           req_i/last_i [N-1:0], data_i [N-1:0][Width-1:0] - requesters
//           gnt_o [N-1:0]        - one-hot beat-accepted strobe
//           fifo_wvalid_o, fifo_wready_i, fifo_wdata_o {idx, payload}
//           lock_o, owner_o, trunc_o - status
module prim_fifo_wr_arb
  import prim_fifo_wr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int Width    = 32,
  parameter int MaxBurst = 16,
  parameter int IdxW     = $clog2(N)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic [N-1:0]               req_i,
  input  logic [N-1:0]               last_i,
  input  logic [N-1:0][Width-1:0]    data_i,
  output logic [N-1:0]               gnt_o,
  output logic                       fifo_wvalid_o,
  input  logic                       fifo_wready_i,
  output logic [IdxW+Width-1:0]      fifo_wdata_o,
  output logic                       lock_o,
  output logic [IdxW-1:0]            owner_o,
  output logic                       trunc_o
);

  localparam int CntW = $clog2(MaxBurst + 1);

  arb_state_e      state_q;
  logic [IdxW-1:0] owner_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [CntW-1:0] beat_cnt_q;
  logic            trunc_q;

  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] winner;
  logic            winner_valid;
  logic            accept;
  logic [CntW-1:0] cnt_inc;

  prim_rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_pick (
    .req_i   (req_i),
    .start_i (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // While locked only the owner may write; if the owner has nothing this
  // cycle the bus simply idles rather than letting someone else in.
  assign winner       = (state_q == ArbLocked) ? owner_q : pick_idx;
  assign winner_valid = (state_q == ArbLocked) ? req_i[owner_q] : pick_valid;

  // Combinational outputs are forced low while reset is asserted so that
  // requests are ignored until release, independent of register timing.
  assign fifo_wvalid_o = rst_ni & winner_valid;
  assign fifo_wdata_o  = rst_ni ? {winner, data_i[winner]} : '0;
  assign accept        = fifo_wvalid_o & fifo_wready_i;

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt_o[gi] = accept && (winner == IdxW'(gi));
  end

  assign cnt_inc = beat_cnt_q + CntW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ArbIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else if (clr_i) begin
      state_q    <= ArbIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      if (accept) begin
        owner_q  <= winner;
        rr_ptr_q <= IdxW'(rr_next(int'(winner), N));
        if (last_i[winner]) begin
          state_q    <= ArbIdle;
          beat_cnt_q <= '0;
        end else if (cnt_inc == CntW'(MaxBurst)) begin
          // Burst limit reached without a last beat: release so that other
          // requesters are not starved, and flag the cut packet.
          state_q    <= ArbIdle;
          beat_cnt_q <= '0;
          trunc_q    <= 1'b1;
        end else begin
          state_q    <= ArbLocked;
          beat_cnt_q <= cnt_inc;
        end
      end
    end
  end

  assign lock_o  = (state_q == ArbLocked);
  assign owner_o = owner_q;
  assign trunc_o = trunc_q;

endmodule

// File: tb/tb_prim_fifo_wr_arb.sv
module tb_prim_fifo_wr_arb;

  localparam int N        = 4;
  localparam int Width    = 8;
  localparam int MaxBurst = 4;
  localparam int IdxW     = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    clr;
  logic [N-1:0]            req;
  logic [N-1:0]            last;
  logic [N-1:0][Width-1:0] data;
  logic [N-1:0]            gnt;
  logic                    wvalid;
  logic                    wready;
  logic [IdxW+Width-1:0]   wdata;
  logic                    lock;
  logic [IdxW-1:0]         owner;
  logic                    trunc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  prim_fifo_wr_arb #(
    .N        (N),
    .Width    (Width),
    .MaxBurst (MaxBurst)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clr_i         (clr),
    .req_i         (req),
    .last_i        (last),
    .data_i        (data),
    .gnt_o         (gnt),
    .fifo_wvalid_o (wvalid),
    .fifo_wready_i (wready),
    .fifo_wdata_o  (wdata),
    .lock_o        (lock),
    .owner_o       (owner),
    .trunc_o       (trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    req    = '0;
    last   = '0;
    data   = '0;
    wready = 1'b1;
    tick();

    // ---- outputs held low in reset even with requests present
    req = 4'b1111;
    #1;
    chk("rst_gnt",    32'(gnt),    32'h0);
    chk("rst_wvalid", 32'(wvalid), 32'h0);
    chk("rst_wdata",  32'(wdata),  32'h0);
    chk("rst_lock",   32'(lock),   32'h0);
    chk("rst_owner",  32'(owner),  32'h0);
    chk("rst_trunc",  32'(trunc),  32'h0);
    tick();

    // ---- round robin with all requesters sending single beats
    rst_n = 1'b1;
    req   = 4'b1111;
    last  = 4'b1111;
    for (int i = 0; i < N; i++) data[i] = 8'hA0 + 8'(i);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_gnt%0d", k),   32'(gnt),   32'(4'b0001 << (k % 4)));
      chk($sformatf("rr_wdata%0d", k), 32'(wdata), {22'd0, 2'(k % 4), 8'hA0 + 8'(k % 4)});
      $display("rr beat %0d: gnt=%b wdata=%h", k, gnt, wdata);
      tick();
    end
    req = '0;

    // ---- clear pointer so req0 has priority, then 3-beat packet on req0
    clr = 1'b1;
    tick();
    clr     = 1'b0;
    req     = 4'b0011;
    last    = 4'b0010;
    data[0] = 8'hB0;
    #1;
    chk("pkt_b1_gnt",  32'(gnt),  32'h1);
    chk("pkt_b1_lock", 32'(lock), 32'h0);
    $display("pkt beat 1: gnt=%b lock=%b", gnt, lock);
    tick();
    // owner stalls: req0 low, req1 still pending -> nothing granted
    req = 4'b0010;
    #1;
    chk("pkt_lock",        32'(lock),   32'h1);
    chk("pkt_owner",       32'(owner),  32'h0);
    chk("pkt_stall_gnt",   32'(gnt),    32'h0);
    chk("pkt_stall_valid", 32'(wvalid), 32'h0);
    $display("pkt owner stall: gnt=%b wvalid=%b", gnt, wvalid);
    tick();
    req     = 4'b0011;
    data[0] = 8'hB1;
    #1;
    chk("pkt_b2_gnt",   32'(gnt),   32'h1);
    chk("pkt_b2_wdata", 32'(wdata), {22'd0, 2'd0, 8'hB1});
    $display("pkt beat 2: gnt=%b wdata=%h", gnt, wdata);
    tick();
    last    = 4'b0011;
    data[0] = 8'hB2;
    #1;
    chk("pkt_b3_gnt",  32'(gnt),  32'h1);
    chk("pkt_b3_lock", 32'(lock), 32'h1);
    $display("pkt beat 3: gnt=%b lock=%b", gnt, lock);
    tick();
    req = 4'b0010;
    #1;
    chk("pkt_next_gnt",  32'(gnt),  32'h2);
    chk("pkt_next_lock", 32'(lock), 32'h0);
    $display("pkt next: gnt=%b", gnt);
    tick();

    // ---- req2 streams last=0 beats; forced release after MaxBurst
    req     = 4'b0100;
    last    = 4'b0000;
    data[2] = 8'hC0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("burst_gnt%0d", k),   32'(gnt),   32'h4);
      chk($sformatf("burst_trunc%0d", k), 32'(trunc), 32'h0);
      $display("burst beat %0d: gnt=%b lock=%b", k, gnt, lock);
      tick();
    end
    req  = 4'b1100;
    last = 4'b1000;
    #1;
    chk("burst_trunc_pulse", 32'(trunc), 32'h1);
    chk("burst_unlock",      32'(lock),  32'h0);
    chk("burst_next_gnt",    32'(gnt),   32'h8);
    $display("burst release: trunc=%b gnt=%b", trunc, gnt);
    tick();
    req  = 4'b0100;
    last = 4'b0000;
    #1;
    chk("burst_trunc_end", 32'(trunc), 32'h0);
    chk("burst_b5_gnt",    32'(gnt),   32'h4);
    $display("burst beat 5: gnt=%b trunc=%b", gnt, trunc);
    tick();
    #1;
    chk("burst_b6_gnt", 32'(gnt), 32'h4);
    tick();
    chk("burst_relock", 32'(lock),  32'h1);
    chk("burst_owner",  32'(owner), 32'h2);
    req = '0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr1_lock",  32'(lock),  32'h0);
    chk("clr1_owner", 32'(owner), 32'h0);

    // ---- FIFO full for 5 cycles while locked on req1
    req     = 4'b0010;
    last    = 4'b0000;
    data[1] = 8'hD1;
    #1;
    chk("full_b1_gnt", 32'(gnt), 32'h2);
    tick();
    wready = 1'b0;
    req    = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("full_gnt%0d", k),    32'(gnt),        32'h0);
      chk($sformatf("full_valid%0d", k),  32'(wvalid),     32'h1);
      chk($sformatf("full_tag%0d", k),    32'(wdata[9:8]), 32'h1);
      chk($sformatf("full_owner%0d", k),  32'(owner),      32'h1);
      chk($sformatf("full_lock%0d", k),   32'(lock),       32'h1);
      $display("full stall %0d: gnt=%b wvalid=%b", k, gnt, wvalid);
      tick();
    end
    // beat count must still be 1: two more beats keep the lock, the fourth cuts
    wready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("full_resume_gnt%0d", k), 32'(gnt), 32'h2);
      tick();
    end
    chk("full_still_locked", 32'(lock),  32'h1);
    chk("full_no_trunc",     32'(trunc), 32'h0);
    #1;
    chk("full_b4_gnt", 32'(gnt), 32'h2);
    tick();
    req  = 4'b0001;
    last = 4'b0001;
    #1;
    chk("full_trunc", 32'(trunc), 32'h1);
    chk("full_after_gnt", 32'(gnt), 32'h1);
    $display("full release: trunc=%b gnt=%b", trunc, gnt);
    tick();

    // ---- clear while locked on owner 3 with two beats taken
    req  = 4'b1000;
    last = 4'b0000;
    #1;
    chk("clr2_b1_gnt", 32'(gnt), 32'h8);
    tick();
    #1;
    chk("clr2_b2_gnt", 32'(gnt), 32'h8);
    tick();
    chk("clr2_lock_pre",  32'(lock),  32'h1);
    chk("clr2_owner_pre", 32'(owner), 32'h3);
    clr  = 1'b1;
    req  = 4'b1001;
    last = 4'b0001;
    tick();
    clr = 1'b0;
    #1;
    chk("clr2_lock",  32'(lock),  32'h0);
    chk("clr2_owner", 32'(owner), 32'h0);
    chk("clr2_gnt",   32'(gnt),   32'h1);
    $display("after clr: lock=%b gnt=%b", lock, gnt);
    tick();

    // ---- reset asserted mid-packet
    req     = 4'b0100;
    last    = 4'b0000;
    #1;
    chk("rst2_b1_gnt", 32'(gnt), 32'h4);
    tick();
    chk("rst2_lock_pre", 32'(lock), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst2_lock",   32'(lock),   32'h0);
    chk("rst2_gnt",    32'(gnt),    32'h0);
    chk("rst2_wvalid", 32'(wvalid), 32'h0);
    chk("rst2_wdata",  32'(wdata),  32'h0);
    chk("rst2_owner",  32'(owner),  32'h0);
    $display("mid-packet reset: lock=%b wvalid=%b", lock, wvalid);
    tick();
    rst_n   = 1'b1;
    req     = 4'b0010;
    last    = 4'b0010;
    data[1] = 8'hE1;
    #1;
    chk("rst2_after_gnt",   32'(gnt),   32'h2);
    chk("rst2_after_wdata", 32'(wdata), {22'd0, 2'd1, 8'hE1});
    $display("after reset: gnt=%b wdata=%h", gnt, wdata);
    tick();
    req = '0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
